// File: rtl/upe_add_seq_pkg.sv
// Shared definitions for the UPE multi-cycle adder/subtractor:
// FSM state encodings, default geometry and the chunk-counter width helper.
package upe_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CHUNK = 16;

  // Bits needed to count NCHUNK chunks; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/upe_add_chunk.sv
// Combinational W-bit adder slice.
// Ports:
//   a, b   : W-bit addends
//   cin    : carry into bit 0
//   sum    : W-bit sum
//   cout   : carry out of the MSB
//   c_msb  : carry into the MSB (paired with cout for signed overflow)
module upe_add_chunk #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  assign sum   = full[W-1:0];
  assign cout  = full[W];
  // The carry into a bit is recovered from its sum and its addend bits.
  assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/upe_add_seq.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB chunk first,
// with a registered carry between chunks.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted when no operation is in flight
//   sub           : 0 = A + B + carryin, 1 = A - B - carryin (borrow-in)
//   A, B, carryin : operands, captured on an accepted start
//   busy          : high while chunks are being processed
//   done          : one-cycle pulse when Out/carryout/overflow are valid
//   Out           : result, written chunk by chunk, held after done
//   carryout      : carry out of the MSB (sub mode: 1 = no borrow)
//   overflow      : signed two's-complement overflow
module upe_add_seq
  import upe_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carryout_q, carryout_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CHUNK-1:0]   chunk_a_c, chunk_b_c, chunk_sum_c;
  logic               chunk_cout_c, chunk_cmsb_c;
  logic               last_chunk_c;
  logic               accept_c;

  // Current chunk of the captured operands.
  assign chunk_a_c    = a_q[cnt_q*CHUNK +: CHUNK];
  assign chunk_b_c    = b_q[cnt_q*CHUNK +: CHUNK];
  assign last_chunk_c = (cnt_q == CNT_W'(NCHUNK - 1));
  // DONE also accepts, so its exit edge can launch the next operation.
  assign accept_c     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  upe_add_chunk #(
    .W (CHUNK)
  ) u_chunk (
    .a     (chunk_a_c),
    .b     (chunk_b_c),
    .cin   (carry_q),
    .sum   (chunk_sum_c),
    .cout  (chunk_cout_c),
    .c_msb (chunk_cmsb_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      out_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      out_q      <= out_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    out_d      = out_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          // Subtraction becomes A + ~B + ~borrow_in; the mode is folded in here.
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          carry_d = carryin ^ sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        out_d[cnt_q*CHUNK +: CHUNK] = chunk_sum_c;
        carry_d = chunk_cout_c;
        if (last_chunk_c) begin
          carryout_d = chunk_cout_c;
          overflow_d = chunk_cmsb_c ^ chunk_cout_c;
          cnt_d      = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Out      = out_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_upe_add_seq.sv
// Directed bench for upe_add_seq: a 64/16 instance and an 8/8 instance.
module tb_upe_add_seq;

  logic        clk;
  logic        rst;

  logic        start, sub, cin;
  logic [63:0] a, b;
  logic        busy, done, co, ov;
  logic [63:0] out;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  out8;

  int n_tests;
  int n_fail;

  upe_add_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(a), .B(b),
    .carryin(cin), .busy(busy), .done(done), .Out(out),
    .carryout(co), .overflow(ov)
  );

  upe_add_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .carryin(cin8), .busy(busy8), .done(done8), .Out(out8),
    .carryout(co8), .overflow(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns 1ns after the accepting edge k.
  task automatic launch(input logic s, input logic [63:0] aa, input logic [63:0] bb,
                        input logic c);
    sub = s; a = aa; b = bb; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done on the 64-bit instance.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy, done, co, ov} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, co, ov});
    end
    n_tests++;
    if (out !== 64'h0) begin
      n_fail++; $display("FAIL reset_out: got %h expected 0", out);
    end
    n_tests++;
    if ({busy8, done8, co8, ov8, out8} !== 12'h000) begin
      n_fail++; $display("FAIL reset8: got %h expected 000", {busy8, done8, co8, ov8, out8});
    end
  endtask

  task automatic test_add_latency();
    launch(1'b0, 64'h5CD5153134D51531, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL add_edge0: busy/done %b expected 10", {busy, done});
    end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done} !== 2'b10) begin
        n_fail++; $display("FAIL add_edge%0d: busy/done %b expected 10", i, {busy, done});
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done} !== 2'b01) begin
      n_fail++; $display("FAIL add_edge4: busy/done %b expected 01", {busy, done});
    end
    n_tests++;
    if (out !== 64'h5CD5153134D51531) begin
      n_fail++; $display("FAIL add_out: got %h expected 5cd5153134d51531", out);
    end
    n_tests++;
    if ({co, ov} !== 2'b10) begin
      n_fail++; $display("FAIL add_co_ov: got %b expected 10", {co, ov});
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL add_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_sub();
    bit ok;
    launch(1'b1, 64'd0, 64'd1, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL sub0_timeout: no done expected done"); end
    n_tests++;
    if (out !== 64'hFFFFFFFFFFFFFFFF) begin
      n_fail++; $display("FAIL sub0_out: got %h expected ffffffffffffffff", out);
    end
    n_tests++;
    if ({co, ov} !== 2'b00) begin
      n_fail++; $display("FAIL sub0_co_ov: got %b expected 00", {co, ov});
    end
    @(posedge clk); #1;
    launch(1'b1, 64'd5, 64'd3, 1'b1);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL sub1_timeout: no done expected done"); end
    n_tests++;
    if (out !== 64'd1) begin
      n_fail++; $display("FAIL sub1_out: got %h expected 1", out);
    end
    n_tests++;
    if ({co, ov} !== 2'b10) begin
      n_fail++; $display("FAIL sub1_co_ov: got %b expected 10", {co, ov});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    bit ok;
    launch(1'b0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ovf_timeout: no done expected done"); end
    n_tests++;
    if (out !== 64'h8000000000000000) begin
      n_fail++; $display("FAIL ovf_out: got %h expected 8000000000000000", out);
    end
    n_tests++;
    if ({co, ov} !== 2'b01) begin
      n_fail++; $display("FAIL ovf_co_ov: got %b expected 01", {co, ov});
    end
    @(posedge clk); #1;
  endtask

  // start held high: accepts at edges 0, 5, 10; operands change mid-run.
  task automatic test_back_to_back();
    int          exp_e [3];
    logic [63:0] exp_v [3];
    int          nd;
    exp_e = '{4, 9, 14};
    exp_v = '{64'd3, 64'd300, 64'd15};
    nd = 0;
    sub = 1'b0; cin = 1'b0; a = 64'd1; b = 64'd2; start = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin a = 64'd100; b = 64'd200; end
      if (e == 6) begin a = 64'd7;   b = 64'd8;   end
      if (done) begin
        n_tests++;
        if (nd >= 3) begin
          n_fail++; $display("FAIL b2b_extra_done: done at edge %0d expected none", e);
        end else begin
          if (e !== exp_e[nd]) begin
            n_fail++; $display("FAIL b2b_done_edge%0d: got %0d expected %0d", nd, e, exp_e[nd]);
          end
          n_tests++;
          if (out !== exp_v[nd]) begin
            n_fail++; $display("FAIL b2b_out%0d: got %h expected %h", nd, out, exp_v[nd]);
          end
        end
        nd++;
      end
    end
    start = 1'b0;
    n_tests++;
    if (nd !== 3) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", nd);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_pulse();
    int nd;
    launch(1'b0, 64'd1, 64'd1, 1'b0);
    @(posedge clk); #1;
    a = 64'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    n_tests++;
    if (nd !== 1) begin
      n_fail++; $display("FAIL busy_pulse_dones: got %0d expected 1", nd);
    end
    n_tests++;
    if (out !== 64'd2) begin
      n_fail++; $display("FAIL busy_pulse_out: got %h expected 2", out);
    end
  endtask

  task automatic test_reset_mid_run();
    int nbusy, nd;
    launch(1'b0, 64'h5CD5153134D51531, 64'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done, co, ov} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b expected 0000", {busy, done, co, ov});
    end
    n_tests++;
    if (out !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_out: got %h expected 0", out);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    nbusy = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) nd++;
    end
    n_tests++;
    if ({nbusy, nd} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL rst_mid_after: busy cycles %0d dones %0d expected 0 0", nbusy, nd);
    end
  endtask

  task automatic test_single_chunk();
    sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_tests++;
    if ({busy8, done8} !== 2'b10) begin
      n_fail++; $display("FAIL w8_edge0: busy/done %b expected 10", {busy8, done8});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({busy8, done8} !== 2'b01) begin
      n_fail++; $display("FAIL w8_edge1: busy/done %b expected 01", {busy8, done8});
    end
    n_tests++;
    if ({out8, co8, ov8} !== 10'b00000000_10) begin
      n_fail++; $display("FAIL w8_result: out %h co %b ov %b expected 00 1 0", out8, co8, ov8);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_done_pulse: got %b expected 0", done8);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_add_latency();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_busy_pulse();
    test_reset_mid_run();
    test_single_chunk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
